// File: rtl/apb_gpio_irq_if.sv
// APB3 slave-side bus bundle for the GPIO interrupt peripheral.
// The bus signal names are kept upper-case so they match the APB signal names.
interface apb_gpio_irq_if;
    logic [4:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO block: per-pin direction, atomic set/clear, synchronised inputs and
// sticky edge interrupts. Every access completes with exactly one wait state.
module apb_gpio_irq #(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_gpio_irq_if.slave       apb,
    output logic                irq,
    inout  wire  [NUM_PINS-1:0] gpio
);
    localparam logic [2:0] REG_CR  = 3'd0;
    localparam logic [2:0] REG_ODR = 3'd1;
    localparam logic [2:0] REG_IDR = 3'd2;
    localparam logic [2:0] REG_SET = 3'd3;
    localparam logic [2:0] REG_CLR = 3'd4;
    localparam logic [2:0] REG_IRE = 3'd5;
    localparam logic [2:0] REG_IFE = 3'd6;
    localparam logic [2:0] REG_ISR = 3'd7;

    typedef logic [NUM_PINS-1:0] pin_t;

    pin_t cr_q, cr_d, odr_q, odr_d, ire_q, ire_d, ife_q, ife_d;
    pin_t isr_q, isr_d, prev_q, prev_d;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;

    logic       commit, wr_en, rd_en;
    logic [2:0] reg_sel;
    pin_t       wdata, rd_word, sync_last, rise, fall, edge_set, w1c;
    logic       unused_bus_bits;

    // The ~pready_q term keeps a held PENABLE from committing a second time.
    assign commit    = apb.PSEL && apb.PENABLE && !pready_q;
    assign wr_en     = commit && apb.PWRITE;
    assign rd_en     = commit && !apb.PWRITE;
    assign reg_sel   = apb.PADDR[4:2];
    assign wdata     = apb.PWDATA[NUM_PINS-1:0];
    assign unused_bus_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign rise      = sync_last & ~prev_q & ~cr_q;
    assign fall      = ~sync_last & prev_q & ~cr_q;
    assign edge_set  = (rise & ire_q) | (fall & ife_q);

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_CR:  rd_word = cr_q;
            REG_ODR: rd_word = odr_q;
            REG_IDR: rd_word = sync_last;
            REG_IRE: rd_word = ire_q;
            REG_IFE: rd_word = ife_q;
            REG_ISR: rd_word = isr_q;
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        cr_d     = cr_q;
        odr_d    = odr_q;
        ire_d    = ire_q;
        ife_d    = ife_q;
        w1c      = '0;
        prdata_d = prdata_q;
        pready_d = commit;
        if (wr_en) begin
            case (reg_sel)
                REG_CR:  cr_d  = wdata;
                REG_ODR: odr_d = wdata;
                REG_SET: odr_d = odr_q | wdata;
                REG_CLR: odr_d = odr_q & ~wdata;
                REG_IRE: ire_d = wdata;
                REG_IFE: ife_d = wdata;
                REG_ISR: w1c   = wdata;
                default: ;
            endcase
        end
        if (rd_en) begin
            prdata_d                 = '0;
            prdata_d[NUM_PINS-1:0]   = rd_word;
        end
        // A new edge in the same cycle as its W1C leaves the bit set.
        isr_d  = (isr_q & ~w1c) | edge_set;
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio};
        prev_d = sync_last;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cr_q     <= '0;
            odr_q    <= '0;
            ire_q    <= '0;
            ife_q    <= '0;
            isr_q    <= '0;
            prev_q   <= '0;
            sync_q   <= '0;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            cr_q     <= cr_d;
            odr_q    <= odr_d;
            ire_q    <= ire_d;
            ife_q    <= ife_d;
            isr_q    <= isr_d;
            prev_q   <= prev_d;
            sync_q   <= sync_d;
            prdata_q <= prdata_d;
            pready_q <= pready_d;
        end
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pad
        assign gpio[i] = cr_q[i] ? odr_q[i] : 1'bz;
    end

    assign apb.PRDATA = prdata_q;
    assign apb.PREADY = pready_q;
    assign irq        = |isr_q;
endmodule

// File: tb/tb_apb_gpio_irq.sv
// Self-checking bench for apb_gpio_irq: directed scenarios plus randomised
// configuration/pad sweeps checked against a register-level reference model.
module tb_apb_gpio_irq;
    localparam int NP = 16;
    localparam int SS = 2;
    localparam logic [31:0] MASK = 32'((64'd1 << NP) - 64'd1);

    localparam logic [2:0] A_CR  = 3'd0;
    localparam logic [2:0] A_ODR = 3'd1;
    localparam logic [2:0] A_IDR = 3'd2;
    localparam logic [2:0] A_SET = 3'd3;
    localparam logic [2:0] A_CLR = 3'd4;
    localparam logic [2:0] A_IRE = 3'd5;
    localparam logic [2:0] A_IFE = 3'd6;
    localparam logic [2:0] A_ISR = 3'd7;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          irq;
    wire  [NP-1:0] gpio;
    logic [NP-1:0] tb_oe = '0;
    logic [NP-1:0] tb_val = '0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    apb_gpio_irq_if bus ();

    apb_gpio_irq #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus),
        .irq    (irq),
        .gpio   (gpio)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // External pad drivers; undriven pads float high so a tri-stated pin reads 1.
    for (genvar i = 0; i < NP; i++) begin : g_ext
        assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
        pullup (gpio[i]);
    end

    // All bus tasks start and end #1 after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [2:0] idx, input logic [31:0] wd,
                            output logic [31:0] rd, output int waits, output logic rdy_after,
                            output int ccyc);
        logic [1:0] lo;
        lo = 2'($urandom_range(0, 3));
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = {idx, lo};
        bus.PWDATA  = wd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        waits = 0;
        do begin
            @(posedge PCLK); #1;
            waits++;
        end while (!bus.PREADY && waits < 8);
        if (!bus.PREADY) waits = 99;
        rd   = bus.PRDATA;
        ccyc = cyc;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        rdy_after = bus.PREADY;
    endtask

    task automatic apb_wr(input logic [2:0] idx, input logic [31:0] wd);
        logic [31:0] rd; int w; logic ra; int cc;
        apb_xfer(1'b1, idx, wd, rd, w, ra, cc);
    endtask

    task automatic apb_rd(input logic [2:0] idx, output logic [31:0] rd);
        int w; logic ra; int cc;
        apb_xfer(1'b0, idx, 32'h0, rd, w, ra, cc);
    endtask

    task automatic settle();
        repeat (SS + 2) @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        tb_oe = '0;
        apb_wr(A_CR, 32'h0000_FFFF);
        apb_wr(A_ODR, 32'h0000_1234);
        apb_wr(A_IRE, 32'hFFFF_FFFF);
        apb_wr(A_IFE, 32'hFFFF_FFFF);
        apb_rd(A_ODR, rd);
        // Reset lands in the access phase of an ODR write, before its commit edge.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = {A_ODR, 2'b00}; bus.PWDATA = 32'h0000_BEEF;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        #1;
        n_checks++;
        if (bus.PREADY !== 1'b0) begin
            n_fail++; $display("FAIL reset_pready: got %b expected 0", bus.PREADY);
        end
        n_checks++;
        if (bus.PRDATA !== 32'h0) begin
            n_fail++; $display("FAIL reset_prdata: got %h expected 0", bus.PRDATA);
        end
        n_checks++;
        if (gpio !== {NP{1'b1}}) begin
            n_fail++; $display("FAIL reset_pads_z: got %h expected all released (%h)", gpio, {NP{1'b1}});
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        tb_oe = '1; tb_val = '0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        for (int a = 0; a < 8; a++) begin
            apb_rd(3'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_read reg%0d: got %h expected 0", a, rd);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
        tb_oe = '0;
        apb_wr(A_CR, 32'hFFFF_FFFF);
        apb_rd(A_CR, rd);
        n_checks++;
        if (rd !== (32'hFFFF_FFFF & MASK)) begin
            n_fail++; $display("FAIL cr_width_mask: got %h expected %h", rd, 32'hFFFF_FFFF & MASK);
        end
        apb_wr(A_CR, 32'h0);
    endtask

    task automatic test_output();
        logic [31:0] rd; int w; logic ra; int cc;
        apb_wr(A_CR, 32'h0000_00FF);
        apb_wr(A_ODR, 32'h0000_00A5);
        n_checks++;
        if (gpio !== 16'hFFA5) begin
            n_fail++; $display("FAIL out_pads: got %h expected ffa5 (upper byte released)", gpio);
        end
        apb_xfer(1'b1, A_SET, 32'h0000_0002, rd, w, ra, cc);
        n_checks++;
        if (w !== 1 || ra !== 1'b0) begin
            n_fail++; $display("FAIL set_handshake: got waits=%0d ready_after=%b expected waits=1 ready_after=0", w, ra);
        end
        apb_rd(A_ODR, rd);
        n_checks++;
        if (rd !== 32'h0000_00A7) begin
            n_fail++; $display("FAIL set_odr: got %h expected 000000a7", rd);
        end
        apb_xfer(1'b1, A_CLR, 32'h0000_0081, rd, w, ra, cc);
        n_checks++;
        if (w !== 1 || ra !== 1'b0) begin
            n_fail++; $display("FAIL clr_handshake: got waits=%0d ready_after=%b expected waits=1 ready_after=0", w, ra);
        end
        apb_xfer(1'b0, A_ODR, 32'h0, rd, w, ra, cc);
        n_checks++;
        if (rd !== 32'h0000_0026 || w !== 1 || ra !== 1'b0) begin
            n_fail++; $display("FAIL clr_odr: got %h waits=%0d ready_after=%b expected 00000026 waits=1 ready_after=0", rd, w, ra);
        end
        n_checks++;
        if (gpio !== 16'hFF26) begin
            n_fail++; $display("FAIL clr_pads: got %h expected ff26", gpio);
        end
        apb_rd(A_SET, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL set_reads_zero: got %h expected 0", rd);
        end
    endtask

    task automatic test_input_sync();
        logic [31:0] rd; int w; logic ra; int cc; int d0; logic exp_b;
        apb_wr(A_CR, 32'h0);
        tb_oe = 16'h0008; tb_val = '0;
        settle();
        tb_val[3] = 1'b1;
        d0 = cyc;
        for (int k = 0; k < 3; k++) begin
            apb_xfer(1'b0, A_IDR, 32'h0, rd, w, ra, cc);
            // Read returns the state after (cc - d0 - 1) edges since the pad moved.
            exp_b = ((cc - d0 - 1) >= SS);
            n_checks++;
            if (rd[3] !== exp_b) begin
                n_fail++; $display("FAIL idr_sync read%0d: got %b expected %b", k, rd[3], exp_b);
            end
        end
    endtask

    task automatic test_rise_irq();
        logic [31:0] rd;
        tb_val[3] = 1'b0;
        settle();
        apb_wr(A_ISR, 32'hFFFF_FFFF);
        apb_wr(A_IRE, 32'h0000_0008);
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL rise_no_retro: got %h expected 0", rd);
        end
        tb_val[3] = 1'b1;
        for (int e = 1; e <= SS + 1; e++) begin
            @(posedge PCLK); #1;
            if (e == SS) begin
                n_checks++;
                if (irq !== 1'b0) begin
                    n_fail++; $display("FAIL rise_irq_early: got %b expected 0 after %0d edges", irq, e);
                end
            end
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL rise_irq_latency: got %b expected 1 after %0d edges", irq, SS + 1);
        end
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_fail++; $display("FAIL rise_isr: got %h expected 00000008", rd);
        end
        tb_val[3] = 1'b0;
        settle();
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_fail++; $display("FAIL rise_fall_ignored: got %h expected 00000008", rd);
        end
        apb_wr(A_ISR, 32'h0000_0008);
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rise_w1c: got isr=%h irq=%b expected 0/0", rd, irq);
        end
    endtask

    task automatic test_fall_mask();
        logic [31:0] rd;
        apb_wr(A_IFE, 32'h0000_0010);
        apb_wr(A_ODR, 32'h0000_0010);
        apb_wr(A_CR, 32'h0000_0010);
        settle();
        apb_wr(A_ODR, 32'h0);
        settle();
        n_checks++;
        if (gpio[4] !== 1'b0) begin
            n_fail++; $display("FAIL fall_out_drive: got %b expected 0", gpio[4]);
        end
        apb_wr(A_ODR, 32'h0000_0010);
        settle();
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL fall_output_masked: got %h expected 0", rd);
        end
        apb_wr(A_CR, 32'h0);
        tb_oe[4] = 1'b1; tb_val[4] = 1'b1;
        settle();
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL fall_cr_change_quiet: got %h expected 0", rd);
        end
        tb_val[4] = 1'b0;
        settle();
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0000_0010 || irq !== 1'b1) begin
            n_fail++; $display("FAIL fall_isr: got isr=%h irq=%b expected 00000010/1", rd, irq);
        end
        apb_wr(A_ISR, 32'h0000_0010);
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        tb_val[3] = 1'b1;
        // Time the W1C commit onto the edge that registers the new rising edge.
        repeat (SS - 1) begin
            @(posedge PCLK); #1;
        end
        apb_wr(A_ISR, 32'h0000_0008);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL collision_irq: got %b expected 1", irq);
        end
        apb_rd(A_ISR, rd);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_fail++; $display("FAIL collision_isr: got %h expected 00000008", rd);
        end
        apb_wr(A_ISR, 32'h0000_0008);
    endtask

    task automatic test_random();
        logic [31:0] rd, raw, m_cr, m_odr, m_ire, m_ife, m_isr, s, c;
        logic [31:0] old_in, new_in, pad_exp, rise, fall;
        for (int it = 0; it < 20; it++) begin
            apb_wr(A_IRE, 32'h0);
            apb_wr(A_IFE, 32'h0);
            raw = $urandom; m_odr = raw & MASK;
            apb_wr(A_ODR, raw);
            raw = $urandom; m_cr = raw & MASK;
            tb_oe = tb_oe & ~m_cr[NP-1:0];
            apb_wr(A_CR, raw);
            tb_oe  = ~m_cr[NP-1:0];
            tb_val = NP'($urandom);
            settle();
            apb_wr(A_ISR, 32'hFFFF_FFFF);
            apb_rd(A_ISR, rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL rand_isr_clear it%0d: got %h expected 0", it, rd);
            end
            raw = $urandom; m_ire = raw & MASK; apb_wr(A_IRE, raw);
            raw = $urandom; m_ife = raw & MASK; apb_wr(A_IFE, raw);
            s = $urandom; c = $urandom;
            apb_wr(A_SET, s);
            apb_wr(A_CLR, c);
            m_odr  = (m_odr | s) & ~c & MASK;
            old_in = 32'(tb_val);
            tb_val = NP'($urandom);
            new_in = 32'(tb_val);
            settle();
            rise    = new_in & ~old_in & ~m_cr & MASK;
            fall    = ~new_in & old_in & ~m_cr & MASK;
            m_isr   = (rise & m_ire) | (fall & m_ife);
            pad_exp = ((m_cr & m_odr) | (~m_cr & new_in)) & MASK;
            n_checks++;
            if (32'(gpio) !== pad_exp) begin
                n_fail++; $display("FAIL rand_pads it%0d: got %h expected %h", it, gpio, pad_exp);
            end
            apb_rd(A_IDR, rd);
            n_checks++;
            if (rd !== pad_exp) begin
                n_fail++; $display("FAIL rand_idr it%0d: got %h expected %h", it, rd, pad_exp);
            end
            apb_rd(A_ISR, rd);
            n_checks++;
            if (rd !== m_isr) begin
                n_fail++; $display("FAIL rand_isr it%0d: got %h expected %h", it, rd, m_isr);
            end
            n_checks++;
            if (irq !== (m_isr != 0)) begin
                n_fail++; $display("FAIL rand_irq it%0d: got %b expected %b", it, irq, (m_isr != 0));
            end
            apb_rd(A_CR, rd);
            n_checks++;
            if (rd !== m_cr) begin
                n_fail++; $display("FAIL rand_cr it%0d: got %h expected %h", it, rd, m_cr);
            end
            apb_rd(A_ODR, rd);
            n_checks++;
            if (rd !== m_odr) begin
                n_fail++; $display("FAIL rand_odr it%0d: got %h expected %h", it, rd, m_odr);
            end
        end
    endtask

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        test_reset();
        test_output();
        test_input_sync();
        test_rise_irq();
        test_fall_mask();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_gpio_irq.md
# apb_gpio_irq

Parametrised APB3 GPIO peripheral with per-pin direction control, atomic set/clear of outputs, synchronised input sampling and maskable edge-detect interrupts. It sits on the APB bus beside the other peripherals and drives one tri-state pad group. It is the successor to the fixed 16-pin GPIO and adds configurable pin count, metastability-safe inputs, atomic bit access and an interrupt line to the CPU.

## Interface
- NUM_PINS, 16, number of GPIO pins (1..32)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- PCLK  input  1  APB clock; all state on rising edge
- PRESET  input  1  reset, asynchronous, active-high
- PADDR  input  5  byte address; PADDR[4:2] selects register, PADDR[1:0] ignored
- PWRITE  input  1  1 = write, 0 = read
- PENABLE  input  1  APB access phase
- PWDATA  input  32  write data
- PSEL  input  1  slave select
- PRDATA  output  32  read data, valid while PREADY=1
- PREADY  output  1  one-cycle transfer-complete pulse
- irq  output  1  level interrupt, OR of all ISR bits
- gpio  inout  NUM_PINS  pads

## Operation
- Register map (word index PADDR[4:2]):
  - 0 CR: RW; bit=1 drives the pin from ODR, bit=0 tri-states it (input)
  - 1 ODR: RW output data
  - 2 IDR: RO; synchronised pad value for all pins, including pins in output mode
  - 3 SET: WO; ODR |= PWDATA; reads 0
  - 4 CLR: WO; ODR &= ~PWDATA; reads 0
  - 5 IRE: RW rising-edge interrupt enable
  - 6 IFE: RW falling-edge interrupt enable
  - 7 ISR: RW1C sticky status; writing 1 clears the bit, writing 0 has no effect
- Bits [31:NUM_PINS] of every register read 0; writes to them are ignored.
- Pad drive: gpio[i] = CR[i] ? ODR[i] : Z. ODR written while CR=0 is stored but not driven.
- Input path: SYNC_STAGES flops per pin, then a prev register holding the last synchronised value. IDR = last synchroniser stage.
- Edge detection:
  - rise[i] = sync[i] & ~prev[i]; fall[i] = ~sync[i] & prev[i]
  - Gated by CR[i]=0; output-mode pins never set ISR.
  - ISR[i] is set when (rise[i] & IRE[i]) | (fall[i] & IFE[i]).
  - Enabling IRE/IFE does not retroactively flag earlier edges.
- Simultaneous set and W1C on the same ISR bit in one cycle: set wins, bit stays 1.
- prev always tracks sync regardless of CR, so a CR change alone creates no spurious edge.
- irq = |ISR, combinational from the ISR register.

## Timing
- Reset values: all registers 0, synchroniser and prev chains 0, PRDATA 0, PREADY 0, irq 0, all pads Z.
- APB transfer:
  - Setup cycle (PSEL=1, PENABLE=0), then access.
  - The slave commits on the first cycle with PSEL&PENABLE&~PREADY: write takes effect at that edge, or PRDATA is registered.
  - PREADY=1 the following cycle, exactly one wait state. PREADY returns to 0 the next cycle.
  - A write is never applied twice within one transfer.
- PRDATA holds its last value between reads.
- Reading IDR returns the value at the commit edge.
- Write-to-pad latency: register update at the commit edge; pad changes the same cycle (combinational from CR/ODR).
- Pad-to-status latency:
  - A pad change before edge k appears in IDR after edge k+SYNC_STAGES-1.
  - ISR and irq set after edge k+SYNC_STAGES.
- A pad pulse shorter than one PCLK period may be missed. This is not an error.
- PRESET mid-transfer: all state returns to reset values immediately. PREADY=0; the bus master restarts the transfer.

## Test plan
- Reset and map: assert PRESET mid-write to ODR -> all reads 0, PREADY=0, gpio all Z. Then write 0xFFFFFFFF to CR with NUM_PINS=16 -> read CR = 0x0000FFFF.
- Output and atomic access:
  - CR=0x00FF, ODR=0x00A5 -> gpio[7:0]=0xA5, gpio[15:8]=Z.
  - SET 0x0002 -> ODR=0x00A7.
  - CLR 0x0081 -> ODR=0x0026; each transfer gives exactly one PREADY pulse one cycle after the first access cycle.
- Input sync: drive gpio[3]=1 with CR=0 -> IDR[3] reads 0 until SYNC_STAGES edges have passed, then reads 1.
- Rising interrupt: IRE=0x0008, toggle gpio[3] 0->1 -> ISR=0x0008 and irq=1 after SYNC_STAGES+1 edges. The 1->0 transition adds nothing. W1C 0x0008 -> ISR=0, irq=0.
- Falling edge and masking:
  - IFE=0x0010, CR[4]=1, toggle ODR[4] -> ISR stays 0.
  - With CR[4]=0, externally drive gpio[4] 1->0 -> ISR[4]=1.
- Collision: schedule the W1C of ISR[3] on the same edge a new rising edge is registered -> ISR[3] remains 1 and irq stays 1.
